// File: rtl/rq_share_arbiter.sv
// Round-robin shared requantizer: NUM_REQ accumulator engines time-share one
// shift-and-saturate-to-int8 stage with a single registered output slot.
module rq_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int SIZE    = 4,
   parameter int SHIFT_W = 5,
   parameter int ID_W    = 2
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        cfg_we,
   input  logic [ID_W-1:0]             cfg_id,
   input  logic [SHIFT_W-1:0]          cfg_shift,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*32*SIZE-1:0]  req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [8*SIZE-1:0]           out_data,
   output logic [ID_W-1:0]             out_id,
   output logic [15:0]                 sat_count
);

   logic [SHIFT_W-1:0] shift_q [NUM_REQ];
   logic [ID_W-1:0]    ptr_q;

   logic               accept;
   logic               grant_found;
   logic               xfer;
   logic [ID_W-1:0]    grant_idx;
   logic [ID_W-1:0]    ptr_next;
   logic [SHIFT_W-1:0] grant_shift;
   logic [32*SIZE-1:0] grant_vec;
   logic [8:0]         lane_rq [SIZE];
   logic [8*SIZE-1:0]  lane_res;
   logic [15:0]        clip_cnt;
   logic [16:0]        sat_sum;

   // Returns {clipped, int8 result} for one accumulator lane.
   function automatic logic [8:0] requant_lane(input logic [31:0] acc,
                                               input logic [SHIFT_W-1:0] sh);
      logic signed [31:0] s;
      logic [8:0]         r;
      s = $signed(acc) >>> sh;
      if (s > 32'sd127)
         r = {1'b1, 8'h7F};
      else if (s < -32'sd128)
         r = {1'b1, 8'h80};
      else
         r = {1'b0, s[7:0]};
      return r;
   endfunction

   assign accept = !out_valid || out_ready;

   // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'((int'(ptr_q) + k) % NUM_REQ);
         end
      end
   end

   assign req_ready = (accept && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;
   assign xfer      = |(req_valid & req_ready);
   assign ptr_next  = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);

   assign grant_vec   = req_data[32*SIZE*int'(grant_idx) +: 32*SIZE];
   assign grant_shift = shift_q[grant_idx];

   for (genvar j = 0; j < SIZE; j++) begin : g_lane
      assign lane_rq[j] = requant_lane(grant_vec[32*j +: 32], grant_shift);
   end

   always_comb begin
      lane_res = '0;
      clip_cnt = '0;
      for (int j = 0; j < SIZE; j++) begin
         lane_res[8*j +: 8] = lane_rq[j][7:0];
         clip_cnt           = clip_cnt + 16'(lane_rq[j][8]);
      end
   end

   assign sat_sum = {1'b0, sat_count} + {1'b0, clip_cnt};

   // A same-cycle config write only lands in shift_q at this edge, so the
   // granted vector above always sees the previous shift value.
   always_ff @(posedge clock) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         sat_count <= '0;
         ptr_q     <= '0;
         for (int i = 0; i < NUM_REQ; i++)
            shift_q[i] <= '0;
      end else begin
         if (cfg_we && int'(cfg_id) < NUM_REQ)
            shift_q[cfg_id] <= cfg_shift;
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= lane_res;
            out_id    <= grant_idx;
            ptr_q     <= ptr_next;
            sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rq_share_arbiter.sv
// Scoreboard bench for rq_share_arbiter: directed vectors push expected
// results; a negedge monitor pops and compares on each output handshake.
module tb_rq_share_arbiter;

   logic         clock;
   logic         reset;
   logic         cfg_we;
   logic [1:0]   cfg_id;
   logic [4:0]   cfg_shift;
   logic [3:0]   req_valid;
   logic [511:0] req_data;
   logic [3:0]   req_ready;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic [1:0]   out_id;
   logic [15:0]  sat_count;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [31:0] rr_data [4] = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130};
   int          rr_seq [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0};

   rq_share_arbiter #(.NUM_REQ(4), .SIZE(4), .SHIFT_W(5), .ID_W(2)) dut (
      .clock     (clock),
      .reset     (reset),
      .cfg_we    (cfg_we),
      .cfg_id    (cfg_id),
      .cfg_shift (cfg_shift),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id),
      .sat_count (sat_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic set_vec(input int r, input logic [31:0] l0, input logic [31:0] l1,
                          input logic [31:0] l2, input logic [31:0] l3);
      req_data[128*r +: 128] = {l3, l2, l1, l0};
   endtask

   task automatic push(input logic [1:0] id, input logic [31:0] data);
      exp_t e;
      e.id   = id;
      e.data = data;
      sb_q.push_back(e);
   endtask

   // Monitor: an output handshake completes at the next posedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: got id %0d data %h expected none", out_id, out_data);
            end else begin
               e = sb_q.pop_front();
               chk("out_id", 32'(out_id), 32'(e.id));
               chk("out_data", out_data, e.data);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] onehot;

      // Reset with random inputs
      reset     = 1'b0;
      cfg_we    = 1'($urandom);
      cfg_id    = 2'($urandom);
      cfg_shift = 5'($urandom);
      req_valid = 4'($urandom);
      out_ready = 1'($urandom);
      for (int i = 0; i < 16; i++)
         req_data[32*i +: 32] = $urandom;
      tick();
      req_valid = 4'($urandom);
      tick();
      reset     = 1'b1;
      cfg_we    = 1'b0;
      req_valid = 4'b0000;
      out_ready = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sat_count", 32'(sat_count), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_id", 32'(out_id), 32'd0);

      // Arithmetic, shift 2 on requester 0
      cfg_we = 1'b1; cfg_id = 2'd0; cfg_shift = 5'd2;
      tick();
      cfg_we = 1'b0;
      set_vec(0, 32'h00000100, 32'h00001000, 32'hFFFFF000, 32'hFFFFFFFB);
      push(2'd0, 32'hFE807F40);
      req_valid = 4'b0001;
      #1 chk("arith_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b0000;
      #1;
      chk("arith_sat_count", 32'(sat_count), 32'd2);
      chk("arith_latency", 32'(out_valid), 32'd1);

      cfg_we = 1'b1; cfg_id = 2'd0; cfg_shift = 5'd1;
      tick();
      cfg_we = 1'b0;
      set_vec(0, 32'h00000010, 32'h0, 32'h0, 32'hFFFFFFFB);
      push(2'd0, 32'hFD000008);
      req_valid = 4'b0001;
      tick();
      req_valid = 4'b0000;
      #1 chk("arith2_sat_count", 32'(sat_count), 32'd2);
      tick();

      // Reset pulse so the pointer restarts at requester 0
      reset = 1'b0;
      tick();
      reset = 1'b1;

      // Round robin, then with requester 1 dropped
      for (int r = 0; r < 4; r++)
         set_vec(r, 32'(16*r), 32'(16*r+1), 32'(16*r+2), 32'(16*r+3));
      for (int k = 0; k < 12; k++) begin
         req_valid = (k < 8) ? 4'b1111 : 4'b1101;
         push(2'(rr_seq[k]), rr_data[rr_seq[k]]);
         onehot = 4'b0001 << rr_seq[k];
         #1 chk("rr_grant", 32'(req_ready), 32'(onehot));
         tick();
      end
      req_valid = 4'b0000;
      #1 chk("rr_last_valid", 32'(out_valid), 32'd1);
      tick();
      #1 chk("rr_drain", 32'(out_valid), 32'd0);

      // Backpressure: hold requester 1's result while requester 2 waits
      out_ready = 1'b0;
      req_valid = 4'b0010;
      push(2'd1, rr_data[1]);
      #1 chk("bp_first_grant", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_ready_low", 32'(req_ready), 32'd0);
         chk("bp_hold_data", out_data, rr_data[1]);
         chk("bp_hold_id", 32'(out_id), 32'd1);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         tick();
      end
      out_ready = 1'b1;
      push(2'd2, rr_data[2]);
      #1 chk("bp_release_grant", 32'(req_ready), 32'h4);
      tick();
      req_valid = 4'b0000;
      #1;
      chk("bp_new_valid", 32'(out_valid), 32'd1);
      chk("bp_new_id", 32'(out_id), 32'd2);

      // Config write colliding with a transfer from the same requester
      set_vec(2, 32'h00000040, 32'h0, 32'h0, 32'h0);
      req_valid = 4'b0100;
      cfg_we = 1'b1; cfg_id = 2'd2; cfg_shift = 5'd3;
      push(2'd2, 32'h00000040);
      #1 chk("cfg_grant_old", 32'(req_ready), 32'h4);
      tick();
      cfg_we = 1'b0;
      push(2'd2, 32'h00000008);
      #1 chk("cfg_grant_new", 32'(req_ready), 32'h4);
      tick();
      req_valid = 4'b0000;
      tick();

      // Counter saturation: four clipped lanes per transfer
      set_vec(0, 32'h7FFFFFFF, 32'h80000000, 32'h00000200, 32'hFFFFFE00);
      req_valid = 4'b0001;
      for (int n = 1; n <= 16390; n++) begin
         push(2'd0, 32'h807F807F);
         tick();
         #1;
         if (n == 16383) chk("sat_below_max", 32'(sat_count), 32'h0000FFFC);
         if (n == 16384) chk("sat_hit_max", 32'(sat_count), 32'h0000FFFF);
         if (n == 16390) chk("sat_stays_max", 32'(sat_count), 32'h0000FFFF);
      end

      // Mid-stream reset drops the held result without a handshake
      reset = 1'b0;
      tick();
      reset     = 1'b1;
      req_valid = 4'b0000;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_sat_count", 32'(sat_count), 32'd0);
      chk("midrst_discarded", 32'(sb_q.size()), 32'd1);
      sb_q.delete();

      push(2'd0, 32'h807F807F);
      req_valid = 4'b0001;
      tick();
      req_valid = 4'b0000;
      #1 chk("post_rst_sat", 32'(sat_count), 32'd4);
      tick();
      tick();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
